// File: rtl/sdram_uart_pkg.sv
// rtl/sdram_uart_pkg.sv - shared command opcodes and tester state encodings
package sdram_uart_pkg;

  // Opcodes understood by the board's UART command front-end
  localparam logic [7:0] CMD_WRITE = 8'h77;
  localparam logic [7:0] CMD_READ  = 8'h72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CMD,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_CMD,
    ST_RD_ADDR,
    ST_RD_RESP,
    ST_DONE
  } tester_state_t;

  typedef enum logic [1:0] {
    SND_READY,
    SND_WAIT_LOW,
    SND_WAIT_HIGH
  } sender_state_t;

endpackage

// File: rtl/uart_byte_sender.sv
// rtl/uart_byte_sender.sv - one-byte transmit handshake towards the uart byte interface
module uart_byte_sender
  import sdram_uart_pkg::*;
(
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_send,
  output logic       o_sent,
  output logic [7:0] o_tx_data,
  output logic       o_tx_req,
  input  logic       i_tx_rdy
);

  sender_state_t state, state_nxt;

  // Handshake state register
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= SND_READY;
    else          state <= state_nxt;
  end

  // Request while the transmitter is idle, then wait for it to go busy and
  // come back idle; o_sent marks the byte as fully accepted and shifted out.
  always_comb begin
    state_nxt = state;
    o_tx_req  = 1'b0;
    o_tx_data = 8'h00;
    o_sent    = 1'b0;
    unique case (state)
      SND_READY: begin
        if (i_send && i_tx_rdy) begin
          o_tx_req  = 1'b1;
          o_tx_data = i_byte;
          state_nxt = SND_WAIT_LOW;
        end
      end
      SND_WAIT_LOW: begin
        if (!i_tx_rdy) state_nxt = SND_WAIT_HIGH;
      end
      SND_WAIT_HIGH: begin
        if (i_tx_rdy) begin
          o_sent    = 1'b1;
          state_nxt = SND_READY;
        end
      end
      default: state_nxt = SND_READY;
    endcase
  end

endmodule

// File: rtl/uart_cmd_tester.sv
// rtl/uart_cmd_tester.sv - UART command-protocol self-test: write pattern, read back, report
module uart_cmd_tester
  import sdram_uart_pkg::*;
#(
  parameter int         NumWords      = 256,
  parameter logic [7:0] Seed          = 8'hA5,
  parameter int         TimeoutCycles = 1_000_000
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic [7:0] o_tx_data,
  output logic       o_tx_req,
  input  logic       i_tx_rdy,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_rdy,
  output logic       o_rx_req,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [8:0] o_err_count,
  output logic [7:0] o_first_err_addr,
  output logic       o_timeout
);

  localparam logic [7:0]  LastAddr = 8'(NumWords - 1);
  localparam logic [23:0] ToLast   = 24'(TimeoutCycles - 1);

  tester_state_t state, state_nxt;
  logic [7:0]  addr;
  logic [23:0] to_cnt;
  logic [7:0]  rx_byte;
  logic        rx_hit;
  logic        send;
  logic [7:0]  send_byte;
  logic        sent;
  logic        start_ok;
  logic        pop;
  logic        resp_byte;
  logic        resp_timeout;
  logic        resolve;

  assign start_ok = i_start && (state == ST_IDLE || state == ST_DONE);
  assign pop      = i_rx_rdy && !o_rx_req;
  // A byte popped during RD_RESP is resolved on the following edge.
  assign resp_byte = (state == ST_RD_RESP) && rx_hit;
  // A pop in the expiry cycle holds off the timeout so the byte wins.
  assign resp_timeout = (state == ST_RD_RESP) && !rx_hit && !pop && (to_cnt == ToLast);
  assign resolve      = resp_byte || resp_timeout;

  assign o_busy = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done = (state == ST_DONE);
  assign o_pass = o_done && (o_err_count == 9'd0) && !o_timeout;

  uart_byte_sender u_sender (
    .i_sys_clk (i_sys_clk),
    .i_rst_n   (i_rst_n),
    .i_byte    (send_byte),
    .i_send    (send),
    .o_sent    (sent),
    .o_tx_data (o_tx_data),
    .o_tx_req  (o_tx_req),
    .i_tx_rdy  (i_tx_rdy)
  );

  // Main FSM state register
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and the byte offered to the sender in each send state
  always_comb begin
    state_nxt = state;
    send      = 1'b0;
    send_byte = 8'h00;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (i_start) state_nxt = ST_WR_CMD;
      end
      ST_WR_CMD: begin
        send      = 1'b1;
        send_byte = CMD_WRITE;
        if (sent) state_nxt = ST_WR_ADDR;
      end
      ST_WR_ADDR: begin
        send      = 1'b1;
        send_byte = addr;
        if (sent) state_nxt = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        send      = 1'b1;
        send_byte = addr ^ Seed;
        if (sent) state_nxt = (addr == LastAddr) ? ST_RD_CMD : ST_WR_CMD;
      end
      ST_RD_CMD: begin
        send      = 1'b1;
        send_byte = CMD_READ;
        if (sent) state_nxt = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        send      = 1'b1;
        send_byte = addr;
        if (sent) state_nxt = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (resolve) state_nxt = (addr == LastAddr) ? ST_DONE : ST_RD_CMD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address counter: wraps to 0 between the write and read passes only
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr <= 8'h00;
    end else if (start_ok) begin
      addr <= 8'h00;
    end else if (state == ST_WR_DATA && sent) begin
      addr <= (addr == LastAddr) ? 8'h00 : addr + 8'd1;
    end else if (resolve && addr != LastAddr) begin
      addr <= addr + 8'd1;
    end
  end

  // Response timeout counter, held at zero outside RD_RESP
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 to_cnt <= 24'd0;
    else if (state != ST_RD_RESP) to_cnt <= 24'd0;
    else if (to_cnt != ToLast)    to_cnt <= to_cnt + 24'd1;
  end

  // Receive pop: one-cycle o_rx_req, byte captured, kept only if popped in RD_RESP
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rx_req <= 1'b0;
      rx_byte  <= 8'h00;
      rx_hit   <= 1'b0;
    end else begin
      o_rx_req <= pop;
      rx_hit   <= pop && (state == ST_RD_RESP);
      if (pop) rx_byte <= i_rx_data;
    end
  end

  // Result registers: cleared on accepted start, updated as each read resolves
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_count      <= 9'd0;
      o_first_err_addr <= 8'h00;
      o_timeout        <= 1'b0;
    end else if (start_ok) begin
      o_err_count      <= 9'd0;
      o_first_err_addr <= 8'h00;
      o_timeout        <= 1'b0;
    end else if (resolve) begin
      if (resp_timeout || rx_byte != (addr ^ Seed)) begin
        o_err_count <= o_err_count + 9'd1;
        if (o_err_count == 9'd0) o_first_err_addr <= addr;
      end
      if (resp_timeout) o_timeout <= 1'b1;
    end
  end

endmodule
